// File: rtl/ifu_fetch_q.sv
// Instruction fetch: PC register, up to MAX_OUTS in-flight ICB fetches, static branch prediction, IBUF_DEPTH-entry buffer.
// Latency rsp -> ifu_valid_o one cycle; fetch is credit-limited by buffer space so responses are never back-pressured.
module ifu_fetch_q #(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                  IBUF_DEPTH = 4,
    parameter int                  MAX_OUTS   = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic [PC_WIDTH-1:0] flush_pc_i,
    output logic                icb_cmd_valid_o,
    input  logic                icb_cmd_ready_i,
    output logic [PC_WIDTH-1:0] icb_cmd_addr_o,
    input  logic                icb_rsp_valid_i,
    output logic                icb_rsp_ready_o,
    input  logic                icb_rsp_err_i,
    input  logic [31:0]         icb_rsp_instr_i,
    output logic                ifu_valid_o,
    input  logic                ifu_ready_i,
    output logic [31:0]         ifu_instr_o,
    output logic [PC_WIDTH-1:0] ifu_pc_o,
    output logic                ifu_prdt_taken_o,
    output logic                ifu_bus_err_o,
    output logic                ifu_misalign_o
);

    localparam int OW = $clog2(MAX_OUTS + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int IW = $clog2(IBUF_DEPTH);
    localparam int PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int SW = CW + 1;

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        logic                prdt;
        logic                err;
        logic                mis;
    } ent_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]       outs_q, outs_d, kill_q, kill_d;
    logic [PC_WIDTH-1:0] pcf_q [MAX_OUTS];
    logic [PW-1:0]       pcf_wr_q, pcf_rd_q;
    ent_t                ib_q [IBUF_DEPTH];
    logic [IW-1:0]       ib_wr_q, ib_rd_q;
    logic [CW-1:0]       ib_cnt_q;

    logic                run, aligned, cmd_hs, rsp_hs, live;
    logic                is_jal, is_bxx, prdt_tk, mis_push, ib_push, ib_pop;
    logic [PC_WIDTH-1:0] rsp_pc, j_imm, b_imm, tgt;
    ent_t                push_ent;

    function automatic logic [PW-1:0] pcf_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign run     = (state_q == S_RUN);
    assign aligned = (fetch_pc_q[1:0] == 2'b00);

    // Buffer credit counts in-flight fetches too, so every response always has a slot.
    assign icb_cmd_valid_o = rst_n_i && run && !flush_i && aligned &&
                             (outs_q < OW'(MAX_OUTS)) &&
                             ((SW'(ib_cnt_q) + SW'(outs_q)) < SW'(IBUF_DEPTH));
    assign icb_cmd_addr_o  = fetch_pc_q;
    assign icb_rsp_ready_o = 1'b1;

    assign cmd_hs = icb_cmd_valid_o && icb_cmd_ready_i;
    assign rsp_hs = icb_rsp_valid_i;
    assign rsp_pc = pcf_q[pcf_rd_q];
    assign live   = rsp_hs && run && !flush_i && (kill_q == '0);
    assign outs_d = outs_q + OW'(cmd_hs) - OW'(rsp_hs);

    assign is_jal = (icb_rsp_instr_i[6:0] == 7'b1101111);
    assign is_bxx = (icb_rsp_instr_i[6:0] == 7'b1100011);
    assign j_imm  = PC_WIDTH'($signed({icb_rsp_instr_i[31], icb_rsp_instr_i[19:12], icb_rsp_instr_i[20],
                                        icb_rsp_instr_i[30:21], 1'b0}));
    assign b_imm  = PC_WIDTH'($signed({icb_rsp_instr_i[31], icb_rsp_instr_i[7], icb_rsp_instr_i[30:25],
                                        icb_rsp_instr_i[11:8], 1'b0}));
    assign tgt    = rsp_pc + (is_jal ? j_imm : b_imm);
    // Backward branches are predicted taken; jalr is never predicted.
    assign prdt_tk = live && !icb_rsp_err_i && (is_jal || (is_bxx && icb_rsp_instr_i[31]));

    assign mis_push = run && !flush_i && !aligned && (outs_q == '0) && (kill_q == '0) &&
                      (ib_cnt_q != CW'(IBUF_DEPTH));
    assign ib_push  = live || mis_push;
    assign ifu_valid_o = (ib_cnt_q != '0);
    assign ib_pop   = ifu_valid_o && ifu_ready_i && !flush_i;

    assign ifu_instr_o      = ib_q[ib_rd_q].instr;
    assign ifu_pc_o         = ib_q[ib_rd_q].pc;
    assign ifu_prdt_taken_o = ib_q[ib_rd_q].prdt;
    assign ifu_bus_err_o    = ib_q[ib_rd_q].err;
    assign ifu_misalign_o   = ib_q[ib_rd_q].mis;

    always_comb begin
        push_ent    = '0;
        push_ent.pc = rsp_pc;
        if (mis_push) begin
            push_ent.pc  = fetch_pc_q;
            push_ent.mis = 1'b1;
        end else if (icb_rsp_err_i) begin
            push_ent.err = 1'b1;
        end else begin
            push_ent.instr = icb_rsp_instr_i;
            push_ent.prdt  = prdt_tk;
        end
    end

    // Later assignments win: flush overrides error and redirect, which override sequential fetch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        state_d    = state_q;
        kill_d     = kill_q;
        if (cmd_hs)
            fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
        if (rsp_hs && (kill_q != '0))
            kill_d = kill_q - OW'(1);
        if (prdt_tk) begin
            fetch_pc_d = tgt;
            kill_d     = outs_d;
        end
        if (live && icb_rsp_err_i) begin
            kill_d  = outs_d;
            state_d = S_HALT;
        end
        if (mis_push)
            state_d = S_HALT;
        if (flush_i) begin
            fetch_pc_d = flush_pc_i;
            state_d    = S_RUN;
            kill_d     = outs_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            outs_q     <= '0;
            kill_q     <= '0;
            pcf_wr_q   <= '0;
            pcf_rd_q   <= '0;
            ib_wr_q    <= '0;
            ib_rd_q    <= '0;
            ib_cnt_q   <= '0;
            for (int i = 0; i < MAX_OUTS; i++)
                pcf_q[i] <= '0;
            for (int i = 0; i < IBUF_DEPTH; i++)
                ib_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outs_q     <= outs_d;
            kill_q     <= kill_d;
            if (cmd_hs) begin
                pcf_q[pcf_wr_q] <= fetch_pc_q;
                pcf_wr_q        <= pcf_inc(pcf_wr_q);
            end
            if (rsp_hs)
                pcf_rd_q <= pcf_inc(pcf_rd_q);
            if (flush_i) begin
                ib_wr_q  <= '0;
                ib_rd_q  <= '0;
                ib_cnt_q <= '0;
            end else begin
                if (ib_push) begin
                    ib_q[ib_wr_q] <= push_ent;
                    ib_wr_q       <= ib_wr_q + IW'(1);
                end
                if (ib_pop)
                    ib_rd_q <= ib_rd_q + IW'(1);
                ib_cnt_q <= ib_cnt_q + CW'(ib_push) - CW'(ib_pop);
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch_q.sv
// Directed bench for ifu_fetch_q: in-order ICB memory model with 1-cycle response latency and hand-computed traces.
module tb_ifu_fetch_q;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        icb_cmd_valid_o;
    logic        icb_cmd_ready_i;
    logic [31:0] icb_cmd_addr_o;
    logic        icb_rsp_valid_i;
    logic        icb_rsp_ready_o;
    logic        icb_rsp_err_i;
    logic [31:0] icb_rsp_instr_i;
    logic        ifu_valid_o;
    logic        ifu_ready_i;
    logic [31:0] ifu_instr_o;
    logic [31:0] ifu_pc_o;
    logic        ifu_prdt_taken_o;
    logic        ifu_bus_err_o;
    logic        ifu_misalign_o;

    always #5 clk_i = ~clk_i;

    ifu_fetch_q dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .icb_cmd_valid_o(icb_cmd_valid_o), .icb_cmd_ready_i(icb_cmd_ready_i), .icb_cmd_addr_o(icb_cmd_addr_o),
        .icb_rsp_valid_i(icb_rsp_valid_i), .icb_rsp_ready_o(icb_rsp_ready_o), .icb_rsp_err_i(icb_rsp_err_i),
        .icb_rsp_instr_i(icb_rsp_instr_i), .ifu_valid_o(ifu_valid_o), .ifu_ready_i(ifu_ready_i),
        .ifu_instr_o(ifu_instr_o), .ifu_pc_o(ifu_pc_o), .ifu_prdt_taken_o(ifu_prdt_taken_o),
        .ifu_bus_err_o(ifu_bus_err_o), .ifu_misalign_o(ifu_misalign_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        prdt;
        logic        err;
        logic        mis;
    } ent_t;

    logic [31:0] cmd_log [$];
    ent_t        pop_log [$];
    logic [31:0] pend    [$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] err_addr;
    logic        err_en;
    logic        hold;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cmd_at(input int i);
        return (i < cmd_log.size()) ? cmd_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic ent_t pop_at(input int i);
        ent_t e;
        e = '1;
        if (i < pop_log.size())
            e = pop_log[i];
        return e;
    endfunction

    // One clock cycle: present the oldest outstanding response, then log handshakes before the edge.
    task automatic cyc();
        logic [31:0] a;
        if (pend.size() > 0 && !hold) begin
            a               = pend.pop_front();
            icb_rsp_valid_i = 1'b1;
            icb_rsp_err_i   = err_en && (a == err_addr);
            icb_rsp_instr_i = icb_rsp_err_i ? 32'h0 : (mem.exists(a) ? mem[a] : NOP);
        end else begin
            icb_rsp_valid_i = 1'b0;
            icb_rsp_err_i   = 1'b0;
            icb_rsp_instr_i = 32'h0;
        end
        #1;
        if (icb_cmd_valid_o && icb_cmd_ready_i) begin
            cmd_log.push_back(icb_cmd_addr_o);
            pend.push_back(icb_cmd_addr_o);
        end
        if (ifu_valid_o && ifu_ready_i && !flush_i)
            pop_log.push_back({ifu_pc_o, ifu_instr_o, ifu_prdt_taken_o, ifu_bus_err_o, ifu_misalign_o});
        @(negedge clk_i);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset(input logic rdy);
        rst_n_i         = 1'b0;
        flush_i         = 1'b0;
        flush_pc_i      = 32'h0;
        icb_cmd_ready_i = 1'b1;
        icb_rsp_valid_i = 1'b0;
        icb_rsp_err_i   = 1'b0;
        icb_rsp_instr_i = 32'h0;
        ifu_ready_i     = rdy;
        err_en          = 1'b0;
        err_addr        = 32'h0;
        hold            = 1'b0;
        pend.delete();
        cmd_log.delete();
        pop_log.delete();
        mem.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        flush_i    = 1'b1;
        flush_pc_i = pc;
        cyc();
        flush_i    = 1'b0;
    endtask

    int base;

    initial begin
        // Reset state
        do_reset(1'b1);
        rst_n_i = 1'b0;
        #1;
        check_eq("rst_cmd_vld", icb_cmd_valid_o, 0);
        check_eq("rst_ifu_vld", ifu_valid_o, 0);
        check_eq("rst_rsp_rdy", icb_rsp_ready_o, 1);
        check_eq("rst_ifu_pc", ifu_pc_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // 1: straight-line NOP stream
        run(10);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t1_cmd%0d", i), cmd_at(i), BASE + 32'(4 * i));
            check_eq($sformatf("t1_pop%0d", i), {pop_at(i).pc, pop_at(i).instr, pop_at(i).prdt},
                     {BASE + 32'(4 * i), NOP, 1'b0});
        end

        // 2: beq -8 at +8 predicted taken, fetch of +C killed
        do_reset(1'b1);
        mem[BASE + 32'h8] = 32'hFE00_0CE3;
        run(10);
        check_eq("t2_cmd0", cmd_at(0), BASE);
        check_eq("t2_cmd2", cmd_at(2), BASE + 32'h8);
        check_eq("t2_cmd3", cmd_at(3), BASE + 32'hC);
        check_eq("t2_cmd4", cmd_at(4), BASE);
        check_eq("t2_cmd5", cmd_at(5), BASE + 32'h4);
        check_eq("t2_pop2", {pop_at(2).pc, pop_at(2).prdt}, {BASE + 32'h8, 1'b1});
        check_eq("t2_pop3", {pop_at(3).pc, pop_at(3).prdt}, {BASE, 1'b0});
        check_eq("t2_pop4", pop_at(4).pc, BASE + 32'h4);

        // 3: stalled consumer fills exactly four credits, release resumes without loss
        do_reset(1'b0);
        run(10);
        check_eq("t3_ncmd", cmd_log.size(), 4);
        check_eq("t3_stall", icb_cmd_valid_o, 0);
        check_eq("t3_full_vld", ifu_valid_o, 1);
        ifu_ready_i = 1'b1;
        run(14);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("t3_cmd%0d", i), cmd_at(i), BASE + 32'(4 * i));
            check_eq($sformatf("t3_pop%0d", i), pop_at(i).pc, BASE + 32'(4 * i));
        end

        // 4: flush with two fetches in flight and a non-empty buffer
        do_reset(1'b0);
        run(3);
        hold = 1'b1;
        run(1);
        check_eq("t4_ncmd", cmd_log.size(), 4);
        check_eq("t4_buf_vld", ifu_valid_o, 1);
        base = cmd_log.size();
        flush_to(BASE + 32'h100);
        check_eq("t4_empty", ifu_valid_o, 0);
        hold        = 1'b0;
        ifu_ready_i = 1'b1;
        run(8);
        check_eq("t4_cmd_first", cmd_at(base), BASE + 32'h100);
        check_eq("t4_pop0", pop_at(0).pc, BASE + 32'h100);
        check_eq("t4_pop1", pop_at(1).pc, BASE + 32'h104);

        // 5: bus error halts fetch until flush
        do_reset(1'b1);
        err_en   = 1'b1;
        err_addr = BASE + 32'h4;
        run(8);
        check_eq("t5_ncmd", cmd_log.size(), 3);
        check_eq("t5_halt_vld", icb_cmd_valid_o, 0);
        check_eq("t5_pop0", {pop_at(0).pc, pop_at(0).err}, {BASE, 1'b0});
        check_eq("t5_pop1", {pop_at(1).pc, pop_at(1).instr, pop_at(1).prdt, pop_at(1).err},
                 {BASE + 32'h4, 32'h0, 1'b0, 1'b1});
        check_eq("t5_npop", pop_log.size(), 2);
        err_en = 1'b0;
        flush_to(BASE);
        run(6);
        check_eq("t5_restart", cmd_at(3), BASE);
        check_eq("t5_pop2", {pop_at(2).pc, pop_at(2).err}, {BASE, 1'b0});

        // 6: misaligned redirect yields one exception entry and halts
        do_reset(1'b1);
        flush_to(BASE + 32'h102);
        run(6);
        check_eq("t6_ncmd", cmd_log.size(), 0);
        check_eq("t6_npop", pop_log.size(), 1);
        check_eq("t6_pop0", {pop_at(0).pc, pop_at(0).instr, pop_at(0).mis, pop_at(0).err},
                 {BASE + 32'h102, 32'h0, 1'b1, 1'b0});
        flush_to(BASE);
        run(4);
        check_eq("t6_restart", cmd_at(0), BASE);

        // 7: forward beq not taken, jal +16 taken
        do_reset(1'b1);
        mem[BASE]          = 32'h0000_0463;
        mem[BASE + 32'h4]  = 32'h0100_006F;
        run(10);
        check_eq("t7_cmd3", cmd_at(3), BASE + 32'h14);
        check_eq("t7_cmd4", cmd_at(4), BASE + 32'h18);
        check_eq("t7_pop0", {pop_at(0).pc, pop_at(0).prdt}, {BASE, 1'b0});
        check_eq("t7_pop1", {pop_at(1).pc, pop_at(1).prdt}, {BASE + 32'h4, 1'b1});
        check_eq("t7_pop2", {pop_at(2).pc, pop_at(2).prdt}, {BASE + 32'h14, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
